// File: rtl/aes_bridge_pkg.sv
// Shared definitions for the AES byte bridge: FSM state encoding, default
// command bytes, timeout default and block geometry.
package aes_bridge_pkg;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_DATA = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4
  } bridge_state_e;

  localparam logic [7:0] DEF_CMD_ENC = 8'h01;
  localparam logic [7:0] DEF_CMD_DEC = 8'h02;
  localparam int         DEF_TIMEOUT = 64;

  localparam int         BLOCK_BYTES   = 16;
  localparam logic [3:0] LAST_BYTE_IDX = 4'(BLOCK_BYTES - 1);

endpackage

// File: rtl/byte_shift128.sv
// 128-bit block register: parallel load, shift a byte in at the LSB end, or
// shift a byte out of the MSB end (zero-filled). Load has priority.
module byte_shift128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] load_data_i,
  input  logic         shift_in_i,
  input  logic [7:0]   byte_i,
  input  logic         shift_out_i,
  output logic [127:0] data_o
);

  logic [127:0] data_q;
  logic [127:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_in_i) begin
      data_d = {data_q[119:0], byte_i};
    end else if (shift_out_i) begin
      data_d = {data_q[119:0], 8'h00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/aes_byte_bridge.sv
// Byte-stream front end for the static-key AES core: collects a command byte
// plus a 16-byte block, runs one core operation and streams the 16-byte result.
module aes_byte_bridge
  import aes_bridge_pkg::*;
#(
  parameter logic [7:0] CMD_ENC = DEF_CMD_ENC,
  parameter logic [7:0] CMD_DEC = DEF_CMD_DEC,
  parameter int         TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         core_load_o,
  output logic         core_dec_o,
  output logic [127:0] core_data_o,
  input  logic [127:0] core_data_i,
  input  logic         core_done_i,
  output logic         busy_o,
  output logic         err_o
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  bridge_state_e state_q;
  logic [3:0]    byte_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          dec_q;
  logic          err_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          load_q;

  // Handshake: a byte moves on in_valid && in_ready or out_valid && out_ready
  // at the rising edge; out_data only changes after an accepted transfer.
  logic in_fire;
  logic out_fire;
  logic is_cmd_byte;

  assign in_fire     = in_valid && in_ready_q;
  assign out_fire    = out_valid_q && out_ready;
  assign is_cmd_byte = (in_data == CMD_ENC) || (in_data == CMD_DEC);

  logic         asm_shift;
  logic         res_capture;
  logic [127:0] asm_block;
  logic [127:0] res_block;

  assign asm_shift   = in_fire && (state_q == S_DATA);
  assign res_capture = (state_q == S_WAIT) && core_done_i;

  byte_shift128 u_asm_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_in_i  (asm_shift),
    .byte_i      (in_data),
    .shift_out_i (1'b0),
    .data_o      (asm_block)
  );

  byte_shift128 u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (res_capture),
    .load_data_i (core_data_i),
    .shift_in_i  (1'b0),
    .byte_i      (8'h00),
    .shift_out_i (out_fire),
    .data_o      (res_block)
  );

  // Only the top byte of the result buffer is ever presented downstream.
  logic unused_res_bits;
  assign unused_res_bits = ^res_block[119:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CMD;
      byte_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      dec_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        S_CMD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            if (is_cmd_byte) begin
              dec_q      <= (in_data == CMD_DEC);
              err_q      <= 1'b0;
              byte_cnt_q <= '0;
              state_q    <= S_DATA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_DATA: begin
          if (in_fire) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == LAST_BYTE_IDX) begin
              in_ready_q <= 1'b0;
              load_q     <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT;
        end

        S_WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
          // A done pulse on the terminal count still wins over the abort.
          if (core_done_i) begin
            byte_cnt_q  <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_SEND;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_CMD;
          end
        end

        S_SEND: begin
          if (out_fire) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == LAST_BYTE_IDX) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_CMD;
            end
          end
        end

        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= S_CMD;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = res_block[127:120];
  assign core_load_o = load_q;
  assign core_dec_o  = dec_q;
  assign core_data_o = asm_block;
  assign busy_o      = (state_q != S_CMD);
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_byte_bridge.sv
// Bench for aes_byte_bridge with a behavioural core stub (FIPS-197 vector
// lookup plus a reversible fallback cipher) and a byte scoreboard.
module tb_aes_byte_bridge;

  localparam logic [7:0]   CMD_ENC = 8'h01;
  localparam logic [7:0]   CMD_DEC = 8'h02;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'h5a3c96e1_0f1e2d3c_4b5a6978_8796a5b4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_data;
  logic         core_load_o;
  logic         core_dec_o;
  logic [127:0] core_data_o;
  logic [127:0] core_data_i = '0;
  logic         core_done_i = 1'b0;
  logic         busy_o;
  logic         err_o;

  aes_byte_bridge #(.CMD_ENC(CMD_ENC), .CMD_DEC(CMD_DEC), .TIMEOUT(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .core_load_o (core_load_o),
    .core_dec_o  (core_dec_o),
    .core_data_o (core_data_o),
    .core_data_i (core_data_i),
    .core_done_i (core_done_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       exp_dec  = 1'b0;
  logic       bp_en    = 1'b0;
  logic       stub_hang = 1'b0;
  int         stray_req = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] core_model(input logic [127:0] b, input logic d);
    logic [127:0] x;
    if (!d && b == PT) return CT;
    if (d && b == CT) return PT;
    if (!d) return {b[119:0], b[127:120]} ^ MASK;
    x = b ^ MASK;
    return {x[7:0], x[127:8]};
  endfunction

  // ---------------- core stub ----------------
  int           lat_left  = 0;
  int           load_cnt  = 0;
  int           stray_ack = 0;
  logic         prev_load = 1'b0;
  logic [127:0] stub_blk  = '0;
  logic         stub_dec  = 1'b0;

  always @(negedge clk) begin
    core_done_i = 1'b0;
    if (rst) begin
      lat_left  = 0;
      prev_load = 1'b0;
    end else begin
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          core_done_i = 1'b1;
          core_data_i = core_model(stub_blk, stub_dec);
        end
      end else if (stray_ack != stray_req) begin
        stray_ack++;
        core_done_i = 1'b1;
        core_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      if (core_load_o) begin
        check("load_single_cycle", prev_load, 1'b0);
        check("dec_at_load", core_dec_o, exp_dec);
        load_cnt++;
        stub_blk = core_data_o;
        stub_dec = core_dec_o;
        if (!stub_hang) lat_left = $urandom_range(2, 10);
      end
      prev_load = core_load_o;
    end
  end

  // ---------------- downstream ready driver ----------------
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (!bp_en) begin
      out_ready = 1'b1;
    end else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 2) == 0) begin
      out_ready  = 1'b0;
      stall_left = $urandom_range(0, 4);
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------- output monitor ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_in_send", in_ready, 1'b0);
        if (prev_stall) check("out_data_stable", out_data, prev_data);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_byte", out_valid, 1'b0);
          end else begin
            exp_byte = exp_q.pop_front();
            check("out_byte", out_data, exp_byte);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    int   n;
    n = 0;
    r = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!r && n < 200) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      n++;
    end
    if (!r) check("in_ready_wait", r, 1'b1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_reached", n < 2000, 1'b1);
  endtask

  task automatic send_txn(input logic [7:0] cmd, input logic [127:0] blk);
    logic [127:0] res;
    int           l0;
    exp_dec = (cmd == CMD_DEC);
    res     = core_model(blk, exp_dec);
    for (int i = 0; i < 16; i++) exp_q.push_back(res[127 - 8*i -: 8]);
    l0 = load_cnt;
    send_byte(cmd, bp_en ? int'($urandom_range(0, 3)) : 0);
    check("err_clear_on_cmd", err_o, 1'b0);
    check("busy_after_cmd", busy_o, 1'b1);
    for (int i = 0; i < 16; i++)
      send_byte(blk[127 - 8*i -: 8], bp_en ? int'($urandom_range(0, 3)) : 0);
    wait_idle();
    check("one_load_per_txn", load_cnt - l0, 1);
    check("err_after_txn", err_o, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  logic [127:0] rblk;
  int           l0;
  int           k;

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {in_ready, out_valid, core_load_o, core_dec_o, busy_o, err_o}, '0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_core_data", core_data_o, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // FIPS-197 encrypt, then decrypt round trip
    send_txn(CMD_ENC, PT);
    send_txn(CMD_DEC, CT);

    // back-pressure on both sides
    bp_en = 1'b1;
    send_txn(CMD_ENC, PT);
    rblk = {$urandom, $urandom, $urandom, $urandom};
    send_txn(CMD_ENC, rblk);
    send_txn(CMD_DEC, core_model(rblk, 1'b0));
    bp_en = 1'b0;

    // illegal command byte
    l0 = load_cnt;
    send_byte(8'h7e, 0);
    check("bad_cmd_err", err_o, 1'b1);
    check("bad_cmd_stays_idle", busy_o, 1'b0);
    check("bad_cmd_in_ready", in_ready, 1'b1);
    check("bad_cmd_no_load", load_cnt - l0, 0);
    send_txn(CMD_ENC, PT);

    // core never answers
    stub_hang = 1'b1;
    exp_dec   = 1'b0;
    send_byte(CMD_ENC, 0);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 0);
    check("tmo_load_seen", core_load_o, 1'b1);
    @(posedge clk);
    #1;
    k = 0;
    while (!err_o && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tmo_cycles", k, 20);
    check("tmo_back_to_idle", busy_o, 1'b0);
    stub_hang = 1'b0;
    send_txn(CMD_DEC, CT);

    // reset in the middle of data collection
    send_byte(CMD_DEC, 0);
    for (int i = 0; i < 7; i++) send_byte(8'ha0 + 8'(i), 0);
    check("mid_busy", busy_o, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ctrl", {in_ready, out_valid, core_load_o, core_dec_o, busy_o, err_o}, '0);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_core_data", core_data_o, '0);
    rst = 1'b0;
    send_txn(CMD_ENC, PT);

    // stray done while idle
    stray_req++;
    repeat (12) @(posedge clk);
    #1;
    check("stray_done_no_out", out_valid, 1'b0);
    check("stray_done_idle", busy_o, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
